morse_char_decoder: RTL and testbench

- Sequencing controller for the seven-segment character display path.
- Samples a debounced, synchronised Morse key and times each mark and space in prescaled ticks.
- Classifies each mark as a dot or dash and assembles up to MAX_SYM symbols.
- On a letter gap, emits the 6-bit character code consumed by the display decoder: 0-9 map to 0..9, A-Z map to 10..35, and 63 is invalid/blank.

---
 rtl/morse_char_decoder_if.sv | 21 ++
 rtl/morse_char_decoder.sv | 226 ++++++++++++++++++++++
 tb/tb_morse_char_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/morse_char_decoder_if.sv
// Key/clear inputs and character outputs of the Morse character decoder.
// The master drives the key side; the decoder is the slave.
interface morse_char_decoder_if;
   logic       key;
   logic       clear;
   logic [5:0] char_code;
   logic       char_valid;
   logic       busy;
   logic [2:0] sym_count;
   logic       word_gap;

   modport master (
      output key, clear,
      input  char_code, char_valid, busy, sym_count, word_gap
   );

   modport slave (
      input  key, clear,
      output char_code, char_valid, busy, sym_count, word_gap
   );
endinterface

// File: rtl/morse_char_decoder.sv
// Morse key decoder: times marks/spaces in prescaled ticks, assembles dots/dashes, emits a 6-bit character code.
// Optional word-gap pulse is enabled by defining MORSE_WORD_GAP_EN.
module morse_char_decoder #(
   parameter int TICK_DIV  = 50000,
   parameter int DOT_MAX   = 2,
   parameter int GAP_TICKS = 4,
   parameter int MAX_SYM   = 5
) (
   input logic                  clk,
   input logic                  reset_n,
   morse_char_decoder_if.slave  mif
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MARK_W  = $clog2(DOT_MAX + 2);
   localparam int GAP_W   = $clog2(GAP_TICKS + 1);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [MARK_W-1:0]  MARK_SAT   = MARK_W'(DOT_MAX + 1);
   localparam logic [MARK_W-1:0]  DOT_LIM    = MARK_W'(DOT_MAX);
   localparam logic [GAP_W-1:0]   GAP_LIM    = GAP_W'(GAP_TICKS);
   localparam logic [2:0]         SYM_LIM    = 3'(MAX_SYM);

   typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [MARK_W-1:0]    mark_cnt_q, mark_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [MAX_SYM-1:0]   pattern_q, pattern_d;
   logic [2:0]           sym_count_q, sym_count_d;
   logic                 overflow_q, overflow_d;
   logic [5:0]           char_code_q, char_code_d;
   logic                 char_valid_q, char_valid_d;
   logic                 busy_q, busy_d;
   logic                 tick;
   logic                 sym_is_dash;
   logic [GAP_W-1:0]     gap_next;
   logic [4:0]           pat5;

   // Pattern holds the first symbol in the highest used bit; dot=0, dash=1.
   function automatic logic [5:0] lookup(input logic [2:0] cnt, input logic [4:0] pat);
      logic [5:0] code;
      case ({cnt, pat})
         8'b001_00000: code = 6'd14;  8'b001_00001: code = 6'd29;
         8'b010_00000: code = 6'd18;  8'b010_00001: code = 6'd10;
         8'b010_00010: code = 6'd23;  8'b010_00011: code = 6'd22;
         8'b011_00000: code = 6'd28;  8'b011_00001: code = 6'd30;
         8'b011_00010: code = 6'd27;  8'b011_00011: code = 6'd32;
         8'b011_00100: code = 6'd13;  8'b011_00101: code = 6'd20;
         8'b011_00110: code = 6'd16;  8'b011_00111: code = 6'd24;
         8'b100_00000: code = 6'd17;  8'b100_00001: code = 6'd31;
         8'b100_00010: code = 6'd15;  8'b100_00100: code = 6'd21;
         8'b100_00110: code = 6'd25;  8'b100_00111: code = 6'd19;
         8'b100_01000: code = 6'd11;  8'b100_01001: code = 6'd33;
         8'b100_01010: code = 6'd12;  8'b100_01011: code = 6'd34;
         8'b100_01100: code = 6'd35;  8'b100_01101: code = 6'd26;
         8'b101_11111: code = 6'd0;   8'b101_01111: code = 6'd1;
         8'b101_00111: code = 6'd2;   8'b101_00011: code = 6'd3;
         8'b101_00001: code = 6'd4;   8'b101_00000: code = 6'd5;
         8'b101_10000: code = 6'd6;   8'b101_11000: code = 6'd7;
         8'b101_11100: code = 6'd8;   8'b101_11110: code = 6'd9;
         default:      code = 6'd63;
      endcase
      return code;
   endfunction

   assign tick        = (presc_q == PRESC_LAST);
   assign sym_is_dash = (mark_cnt_q > DOT_LIM);
   assign gap_next    = gap_cnt_q + GAP_W'(tick);
   assign pat5        = 5'(pattern_q);

   always_comb begin
      presc_d      = tick ? '0 : presc_q + 1'b1;
      state_d      = state_q;
      mark_cnt_d   = mark_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      pattern_d    = pattern_q;
      sym_count_d  = sym_count_q;
      overflow_d   = overflow_q;
      char_code_d  = char_code_q;
      char_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (mif.key) begin
               state_d    = MARK;
               mark_cnt_d = '0;
            end
         end
         MARK: begin
            if (!mif.key) begin
               if (sym_count_q < SYM_LIM) begin
                  pattern_d   = (pattern_q << 1) | MAX_SYM'(sym_is_dash);
                  sym_count_d = sym_count_q + 3'd1;
               end else begin
                  overflow_d = 1'b1;
               end
               state_d   = SPACE;
               gap_cnt_d = '0;
            end else if (tick && mark_cnt_q != MARK_SAT) begin
               mark_cnt_d = mark_cnt_q + 1'b1;
            end
         end
         SPACE: begin
            // Gap expiry wins over a key rise in the same cycle.
            if (gap_next >= GAP_LIM) begin
               state_d      = EMIT;
               char_code_d  = overflow_q ? 6'd63 : lookup(sym_count_q, pat5);
               char_valid_d = 1'b1;
               pattern_d    = '0;
               sym_count_d  = '0;
               overflow_d   = 1'b0;
               gap_cnt_d    = '0;
            end else if (mif.key) begin
               state_d    = MARK;
               mark_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_next;
            end
         end
         default: begin
            state_d    = mif.key ? MARK : IDLE;
            mark_cnt_d = '0;
         end
      endcase

      if (mif.clear) begin
         state_d      = IDLE;
         pattern_d    = '0;
         sym_count_d  = '0;
         overflow_d   = 1'b0;
         mark_cnt_d   = '0;
         gap_cnt_d    = '0;
         char_code_d  = char_code_q;
         char_valid_d = 1'b0;
      end

      busy_d = (state_d == MARK) || (state_d == SPACE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         mark_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         pattern_q    <= '0;
         sym_count_q  <= '0;
         overflow_q   <= 1'b0;
         char_code_q  <= 6'd63;
         char_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         mark_cnt_q   <= mark_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         pattern_q    <= pattern_d;
         sym_count_q  <= sym_count_d;
         overflow_q   <= overflow_d;
         char_code_q  <= char_code_d;
         char_valid_q <= char_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign mif.char_code  = char_code_q;
   assign mif.char_valid = char_valid_q;
   assign mif.busy       = busy_q;
   assign mif.sym_count  = sym_count_q;

`ifdef MORSE_WORD_GAP_EN
   localparam int WG_TICKS = (7 * GAP_TICKS) / 3;
   localparam int WG_W     = $clog2(WG_TICKS + 1);
   localparam logic [WG_W-1:0] WG_LAST = WG_W'(WG_TICKS - 1);

   logic [WG_W-1:0] wg_cnt_q, wg_cnt_d;
   logic            wg_arm_q, wg_arm_d;
   logic            word_gap_q, word_gap_d;

   // Armed on EMIT->IDLE; fires once, then stays quiet until the next emit.
   always_comb begin
      wg_cnt_d   = wg_cnt_q;
      wg_arm_d   = wg_arm_q;
      word_gap_d = 1'b0;
      if (mif.clear) begin
         wg_cnt_d = '0;
         wg_arm_d = 1'b0;
      end else if (state_q == EMIT && state_d == IDLE) begin
         wg_cnt_d = '0;
         wg_arm_d = 1'b1;
      end else if (state_q == IDLE) begin
         if (mif.key) begin
            wg_cnt_d = '0;
            wg_arm_d = 1'b0;
         end else if (wg_arm_q && tick) begin
            if (wg_cnt_q == WG_LAST) begin
               word_gap_d = 1'b1;
               wg_arm_d   = 1'b0;
               wg_cnt_d   = '0;
            end else begin
               wg_cnt_d = wg_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wg_cnt_q   <= '0;
         wg_arm_q   <= 1'b0;
         word_gap_q <= 1'b0;
      end else begin
         wg_cnt_q   <= wg_cnt_d;
         wg_arm_q   <= wg_arm_d;
         word_gap_q <= word_gap_d;
      end
   end

   assign mif.word_gap = word_gap_q;
`else
   assign mif.word_gap = 1'b0;
`endif

endmodule

// File: tb/tb_morse_char_decoder.sv
// Randomized bench for morse_char_decoder: symbol strings are generated, expected codes come from a
// Morse table lookup and are queued; a monitor compares them against each char_valid pulse.
module tb_morse_char_decoder;
   localparam int TICK_DIV  = 1;
   localparam int DOT_MAX   = 2;
   localparam int GAP_TICKS = 4;
   localparam int MAX_SYM   = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   morse_char_decoder_if mif();

   morse_char_decoder #(
      .TICK_DIV(TICK_DIV), .DOT_MAX(DOT_MAX), .GAP_TICKS(GAP_TICKS), .MAX_SYM(MAX_SYM)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .mif(mif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int last_code = 63;

   // Index = character code: 0-9 then A-Z.
   string morse_tab[36] = '{
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----.",
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..", "--",
      "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

   function automatic int ref_code(string s);
      if (s.len() > MAX_SYM) return 63;
      for (int i = 0; i < 36; i++)
         if (morse_tab[i] == s) return i;
      return 63;
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Key level is sampled by exactly n rising edges.
   task automatic hold(logic v, int n);
      mif.key = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // With TICK_DIV=1 a mark held H edges reaches count H-1: H<=3 is a dot, H>=4 a dash.
   // A letter gap of exactly GAP_TICKS edges eats the first edge of the following mark.
   task automatic send_char(string syms, int gap, bit shortened);
      int h;
      exp_q.push_back(ref_code(syms));
      last_code = ref_code(syms);
      for (int i = 0; i < syms.len(); i++) begin
         h = (syms[i] == "-") ? $urandom_range(4, 7) : $urandom_range(1, 3);
         if (i == 0 && shortened) h = h + 1;
         hold(1'b1, h);
         if (i < syms.len() - 1) hold(1'b0, $urandom_range(1, 3));
         else                    hold(1'b0, gap);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && mif.char_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_char_valid: got code %0d, expected no pulse (t=%0t)",
                     mif.char_code, $time);
         end else begin
            int e;
            e = exp_q.pop_front();
            $display("char: code=%0d expect=%0d", mif.char_code, e);
            check("char_code", mif.char_code, e);
            check("busy_in_emit", mif.busy, 0);
`ifndef MORSE_WORD_GAP_EN
            check("word_gap_tied_low", mif.word_gap, 0);
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      string directed[7] = '{".", "-", ".-", "-.", "-----", ".----", "......"};
      string s;
      int gap, prev_gap, k_seen;
      bit seen;

      mif.key = 1'b0;
      mif.clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_char_code", mif.char_code, 63);
      check("rst_char_valid", mif.char_valid, 0);
      check("rst_busy", mif.busy, 0);
      check("rst_sym_count", mif.sym_count, 0);
      check("rst_word_gap", mif.word_gap, 0);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;

      prev_gap = 8;
      for (int c = 0; c < 47; c++) begin
         if (c < 7) s = directed[c];
         else begin
            s = "";
            for (int j = 0; j < int'($urandom_range(1, 6)); j++)
               s = {s, ($urandom_range(0, 1) == 1) ? "-" : "."};
         end
         gap = (c == 0) ? GAP_TICKS : $urandom_range(4, 8);
         send_char(s, gap, prev_gap == GAP_TICKS);
         prev_gap = gap;
      end
      hold(1'b0, 12);

      // Six dots: count saturates, character is blank.
      exp_q.push_back(63);
      last_code = 63;
      for (int i = 0; i < 6; i++) begin
         hold(1'b1, 1);
         hold(1'b0, 2);
      end
      check("ovf_sym_count", mif.sym_count, MAX_SYM);
      hold(1'b0, 10);

      // Abort a three-symbol partial character from SPACE.
      hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 4); hold(1'b0, 2);
      check("pre_clear_sym_count", mif.sym_count, 3);
      check("pre_clear_busy", mif.busy, 1);
      mif.clear = 1'b1;
      @(posedge clk);
      #1;
      mif.clear = 1'b0;
      check("clear_sym_count", mif.sym_count, 0);
      check("clear_busy", mif.busy, 0);
      check("clear_char_code", mif.char_code, last_code);
      hold(1'b0, 20);

      // Asynchronous reset in the middle of the third mark.
      hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 5); hold(1'b0, 2);
      check("pre_rst_sym_count", mif.sym_count, 2);
      mif.key = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_char_code", mif.char_code, 63);
      check("arst_char_valid", mif.char_valid, 0);
      check("arst_busy", mif.busy, 0);
      check("arst_sym_count", mif.sym_count, 0);
      check("arst_word_gap", mif.word_gap, 0);
      last_code = 63;
      mif.key = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      hold(1'b0, 30);

      // E, then a long idle: word-gap timing (1 EMIT->IDLE edge + 9 ticks) or tied low.
      exp_q.push_back(14);
      last_code = 14;
      hold(1'b1, 1);
      mif.key = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mif.char_valid) seen = 1'b1;
      end
      check("e_emitted", int'(seen), 1);
      k_seen = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (mif.word_gap && k_seen == 0) k_seen = k;
      end
`ifdef MORSE_WORD_GAP_EN
      check("word_gap_delay", k_seen, 10);
`else
      check("word_gap_never", k_seen, 0);
`endif
      hold(1'b0, 5);
      check("char_code_held", mif.char_code, last_code);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
